// File: rtl/inst_ram_loader.sv
// ---------------------------------------------------------------------------
// inst_ram_loader
//
// Writer side of the 32-entry instruction RAM. A byte stream (for example from
// a UART receiver) carries a program image: one length byte N, then 4*N data
// bytes in big-endian word order. Each completed word is written to the RAM
// at byte address word_index*4. The CPU is held in reset for the duration of
// the load and released when the image is complete (or rejected).
//
// Optional feature (macro LOADER_CHECKSUM_EN): after the Nth word one more
// byte is accepted and compared against the XOR of all 4*N data bytes. A
// mismatch ends the load in the error state. Words already written are kept.
//
// Parameters:
//   DEPTH  number of instruction words in the target RAM (max image length)
//   CNT_W  width of the word counters (must hold DEPTH, at most 8)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle pulse, begins a load from IDLE, DONE or ERR
//   byte_in      stream byte
//   byte_valid   byte_in is valid this cycle
//   byte_ready   loader accepts the byte this cycle (valid && ready = transfer)
//   we           instruction RAM write enable, one cycle per word
//   waddr        byte address of the word being written (word_index*4)
//   wdata        assembled instruction word
//   cpu_hold     holds the CPU in reset while a load is in progress
//   busy         load in progress (LEN, DATA, WRITE, CHK)
//   done         sticky: last load completed
//   err          sticky: last load rejected
//   words_loaded words written so far in the current load
// ---------------------------------------------------------------------------
module inst_ram_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0] DEPTH_B = 9'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd6;
`endif

  logic [2:0]       state;
  logic [1:0]       bcnt;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] wl;
  logic [31:0]      word;
  logic             accept;
  logic             len_bad;
  logic [CNT_W-1:0] wl_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign accept  = byte_valid && byte_ready;
  assign len_bad = (byte_in == 8'd0) || ({1'b0, byte_in} > DEPTH_B);
  assign wl_next = wl + CNT_W'(1);

  // All outputs decode from registered state, so none depends combinationally
  // on the inputs. we is high for the whole WRITE cycle, which also means a
  // reset arriving during WRITE still lets that write reach the RAM.
`ifdef LOADER_CHECKSUM_EN
  assign byte_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign busy       = byte_ready || (state == S_WRITE);
`else
  assign byte_ready = (state == S_LEN) || (state == S_DATA);
  assign busy       = byte_ready || (state == S_WRITE);
`endif
  assign cpu_hold     = busy;
  assign we           = (state == S_WRITE);
  assign done         = (state == S_DONE);
  assign err          = (state == S_ERR);
  assign words_loaded = wl;
  assign wdata        = word;
  // Only the word-index bits are carried so the upper address bits stay zero
  // even after the counter reaches DEPTH.
  assign waddr        = {{(30-AW){1'b0}}, wl[AW-1:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      bcnt  <= 2'd0;
      len   <= '0;
      wl    <= '0;
      word  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum  <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_LEN;
            bcnt  <= 2'd0;
            wl    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum  <= 8'd0;
`endif
          end
        end
        S_LEN: begin
          if (accept) begin
            if (len_bad) begin
              state <= S_ERR;
            end else begin
              len   <= CNT_W'(byte_in);
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            // Shifting in from the bottom leaves the first byte in [31:24].
            word <= {word[23:0], byte_in};
            bcnt <= bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
            if (bcnt == 2'd3) begin
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          wl <= wl_next;
          if (wl_next == len) begin
`ifdef LOADER_CHECKSUM_EN
            state <= S_CHK;
`else
            state <= S_DONE;
`endif
          end else begin
            state <= S_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            state <= (byte_in == csum) ? S_DONE : S_ERR;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/inst_ram_loader.md
Name: inst_ram_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream (e.g. from a UART receiver) and assembles it into 32-bit MIPS instruction words.
- Writes each completed word into the 32-entry instruction RAM, whose read port indexes words by addr[6:2].
- Holds the CPU in reset while a program image is loaded, then releases it.

Parameters:
- DEPTH, 32, number of instruction words in the target RAM (max image length).
- CNT_W, 6, width of the word counters (must hold DEPTH).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load. Ignored unless in IDLE, DONE or ERR.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in valid this cycle.
- byte_ready  output  1  loader accepts the byte this cycle; transfer occurs when byte_valid && byte_ready.
- we  output  1  instruction RAM write enable, one-cycle pulse per word.
- waddr  output  32  byte address of the word, = word_index*4 (bits [1:0] always 0, bits [31:7] always 0).
- wdata  output  32  assembled instruction word.
- cpu_hold  output  1  high from start until DONE or ERR; drives CPU reset.
- busy  output  1  high in LEN, DATA, WRITE (and CHK when enabled).
- done  output  1  sticky high in DONE.
- err  output  1  sticky high in ERR.
- words_loaded  output  CNT_W  words written so far in the current load.

Behaviour:
- Reset values:
  - State is IDLE.
  - byte_ready=0, we=0, waddr=0, wdata=0, cpu_hold=0, busy=0, done=0, err=0, words_loaded=0.
  - Internal byte counter is 0 and length register is 0.
- States and transitions:
  - IDLE: byte_ready=0. On start: cpu_hold=1, clear words_loaded/done/err, go to LEN.
  - LEN: byte_ready=1. The first accepted byte is N, the word count.
    - N==0 or N>DEPTH: go to ERR.
    - Otherwise latch N and go to DATA.
  - DATA: byte_ready=1. Accept bytes big-endian.
    - First byte goes to wdata[31:24], then [23:16], [15:8], and the fourth byte to [7:0].
    - On the 4th accepted byte, go to WRITE.
  - WRITE: byte_ready=0. The cycle after the 4th byte, we=1 for exactly one cycle, with waddr = words_loaded*4 and wdata stable.
    - words_loaded increments on the same edge that ends WRITE.
    - If the new count == N: go to DONE (or CHK when CHECKSUM_EN is defined).
    - Otherwise go back to DATA.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start begins a new load.
  - ERR: err=1, cpu_hold=0, byte_ready=0, no further writes. start begins a new load.
- Latency:
  - 4th byte accepted at edge k; we is high during the cycle after edge k.
  - Minimum 5 cycles per word.
- Stall rules:
  - byte_valid=0 in LEN or DATA: hold state, no timeout.
  - Bytes offered while byte_ready=0 are not consumed. The producer must hold them.
- Sequencing:
  - Words are written sequentially from address 0; no wrap.
  - N==DEPTH writes words 0..31 (last waddr 0x7C).
- Interrupting a load:
  - start during LEN, DATA or WRITE is ignored.
  - rst at any point returns to IDLE. RAM contents already written are not rolled back.
  - rst coincident with a WRITE cycle: the write still occurs (we was already asserted combinationally from state); all registers then reset.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: after the Nth word, state CHK accepts one further byte. It is compared to the XOR of all 4N data bytes (the N byte excluded).
  - Match: go to DONE.
  - Mismatch: go to ERR. Words already written remain written.
- Undefined: no CHK state; DONE follows the Nth write directly, and err arises only from an illegal N.

Test Plan:
- Reset then idle: hold rst 2 cycles, stream bytes without start -> byte_ready=0, we never high, all outputs at reset values.
- Basic load, N=2, bytes 3C 01 11 11 3C 02 22 22 with byte_valid held high:
  - we pulses twice: waddr=0x00/wdata=0x3C011111, then waddr=0x04/wdata=0x3C022222.
  - done=1, cpu_hold falls, words_loaded=2.
- Stall: same image with byte_valid toggling 1/0 every cycle -> identical writes, no duplicate or lost bytes, byte_ready=0 in each WRITE cycle.
- Illegal length: N=0 and, separately, N=33 -> err=1, cpu_hold=0, no we pulse.
- Full depth: N=32 with word i = 0x000000i0 -> 32 writes, final waddr=0x7C, wdata=0x000001F0, done=1.
- Reset mid-load: rst after 6 data bytes of an N=3 image -> exactly one write observed (0x00). State returns to IDLE, words_loaded=0, and a new start/load succeeds.
- With LOADER_CHECKSUM_EN: N=1, bytes 11 22 33 44:
  - Checksum 0x44 -> done=1.
  - Checksum 0x45 -> err=1, with word 0x11223344 still written at address 0.
